// File: rtl/mmio_pkg.sv
// Shared constants and types for the memory-mapped UART transmitter.
package mmio_pkg;

  localparam logic [3:0] OFS_TXDATA  = 4'h0;
  localparam logic [3:0] OFS_STATUS  = 4'h4;
  localparam logic [3:0] OFS_BAUDDIV = 4'h8;

  localparam int ST_FULL    = 0;
  localparam int ST_EMPTY   = 1;
  localparam int ST_BUSY    = 2;
  localparam int ST_OVF     = 3;
  localparam int ST_CNT_LSB = 4;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_tx_state_t;

endpackage

// File: rtl/mmio_uart_tx_if.sv
// Core data-memory bus as seen by a memory-mapped peripheral.
interface mmio_uart_tx_if;
  import mmio_pkg::*;

  logic        MemWrite;
  logic [31:0] Addr;
  logic [31:0] WriteData;
  logic [31:0] RdData;
  logic        Sel;

  modport master (output MemWrite, Addr, WriteData, input RdData, Sel);
  modport slave  (input MemWrite, Addr, WriteData, output RdData, Sel);

endinterface

// File: rtl/mmio_uart_tx_sync_fifo.sv
// Synchronous first-word-fall-through FIFO; a push while full succeeds when a pop shares the cycle.
module sync_fifo
  import mmio_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp;
  logic [AW-1:0]    rp;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rp];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + AW'(1);
      if (do_pop)  rp <= rp + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= din;
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: register window on the core data bus, TX FIFO and bit FSM.
module mmio_uart_tx
  import mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h1000_0000,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 4
) (
  input  logic          clk,
  input  logic          reset,
  mmio_uart_tx_if.slave bus,
  output logic          TxD,
  output logic          TxBusy
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  function automatic logic [15:0] eff_div(input logic [15:0] d);
    return (d == 16'd0) ? 16'd1 : d;
  endfunction

  logic [3:0]     reg_ofs;
  logic           wr_en;
  logic           push_req;
  logic           ovf_set;
  logic           ovf_clr;
  logic           ovf;
  logic [15:0]    bauddiv;

  logic [7:0]     fifo_dout;
  logic           fifo_full;
  logic           fifo_empty;
  logic [CW-1:0]  fifo_count;
  logic [3:0]     cnt4;
  logic           pop;

  uart_tx_state_t state, state_n;
  logic [15:0]    cnt, cnt_n;
  logic [15:0]    div_act, div_n;
  logic [2:0]     bit_idx, bit_n;
  logic [7:0]     shreg, sh_n;
  logic           bit_end;

  logic           unused_bits;
  assign unused_bits = ^{bus.Addr[1:0], bus.WriteData[31:16]};

  assign bus.Sel  = (bus.Addr[31:4] == BASE_ADDR[31:4]);
  assign reg_ofs  = {bus.Addr[3:2], 2'b00};
  assign wr_en    = bus.Sel & bus.MemWrite;
  assign push_req = wr_en & (reg_ofs == OFS_TXDATA);
  // A full FIFO still accepts the byte when the FSM pops in the same cycle.
  assign ovf_set  = push_req & fifo_full & ~pop;
  assign ovf_clr  = wr_en & (reg_ofs == OFS_STATUS) & bus.WriteData[3];
  assign cnt4     = 4'(fifo_count);

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_req),
    .pop   (pop),
    .din   (bus.WriteData[7:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf     <= 1'b0;
      bauddiv <= 16'(CLKS_PER_BIT);
    end else begin
      if (wr_en && reg_ofs == OFS_BAUDDIV) bauddiv <= bus.WriteData[15:0];
      if (ovf_set)      ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
    end
  end

  always_comb begin
    bus.RdData = '0;
    if (bus.Sel) begin
      case (reg_ofs)
        OFS_STATUS: begin
          bus.RdData[ST_FULL]                   = fifo_full;
          bus.RdData[ST_EMPTY]                  = fifo_empty;
          bus.RdData[ST_BUSY]                   = TxBusy;
          bus.RdData[ST_OVF]                    = ovf;
          bus.RdData[ST_CNT_LSB+3:ST_CNT_LSB]   = cnt4;
        end
        OFS_BAUDDIV: bus.RdData[15:0] = bauddiv;
        default:     bus.RdData       = '0;
      endcase
    end
  end

  // TX bit engine: control state is reset, the shift/divisor datapath is not.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_n;
    end
  end

  always_ff @(posedge clk) begin
    shreg   <= sh_n;
    div_act <= div_n;
  end

  assign bit_end = (cnt == div_act - 16'd1);

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    bit_n   = bit_idx;
    sh_n    = shreg;
    div_n   = div_act;
    pop     = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          sh_n    = fifo_dout;
          div_n   = eff_div(bauddiv);
          cnt_n   = '0;
          state_n = START;
        end
      end
      START: begin
        if (bit_end) begin
          cnt_n   = '0;
          bit_n   = '0;
          state_n = DATA;
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_n = '0;
          sh_n  = {1'b0, shreg[7:1]};
          if (bit_idx == 3'd7) state_n = STOP;
          else                 bit_n   = bit_idx + 3'd1;
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end
      STOP: begin
        if (bit_end) begin
          cnt_n = '0;
          // Chain straight into the next frame so queued bytes leave without an idle gap.
          if (!fifo_empty) begin
            pop     = 1'b1;
            sh_n    = fifo_dout;
            div_n   = eff_div(bauddiv);
            state_n = START;
          end else begin
            state_n = IDLE;
          end
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign TxBusy = (state != IDLE);
  assign TxD    = (state == START) ? 1'b0 :
                  (state == DATA)  ? shreg[0] : 1'b1;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx: register access, frame timing, FIFO overflow, divisor update, reset.
module tb_mmio_uart_tx;
  localparam logic [31:0] BASE    = 32'h1000_0000;
  localparam logic [31:0] A_TX    = BASE + 32'h0;
  localparam logic [31:0] A_ST    = BASE + 32'h4;
  localparam logic [31:0] A_BAUD  = BASE + 32'h8;
  localparam logic [31:0] A_RSV   = BASE + 32'hC;
  localparam logic [31:0] A_OUT   = BASE + 32'h10;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic TxD;
  logic TxBusy;
  int   checks = 0;
  int   errors = 0;

  mmio_uart_tx_if bus();

  mmio_uart_tx #(
    .BASE_ADDR    (BASE),
    .CLKS_PER_BIT (16),
    .FIFO_DEPTH   (4)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .bus    (bus),
    .TxD    (TxD),
    .TxBusy (TxBusy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
    bus.MemWrite  = 1'b1;
    bus.Addr      = a;
    bus.WriteData = d;
    @(negedge clk);
    bus.MemWrite  = 1'b0;
  endtask

  task automatic bus_rd(input logic [31:0] a, input logic [31:0] exp, input string tag);
    bus.MemWrite = 1'b0;
    bus.Addr     = a;
    #1;
    chk(tag, bus.RdData, exp);
  endtask

  // Expects to be called at the negedge just before the frame's START edge.
  task automatic check_frame(input logic [7:0] b, input int div, input string tag);
    int   k;
    logic e;
    for (int i = 0; i < 10 * div; i++) begin
      @(negedge clk);
      k = i / div;
      if (k == 0)      e = 1'b0;
      else if (k == 9) e = 1'b1;
      else             e = b[k-1];
      chk($sformatf("%s txd slot%0d cyc%0d", tag, k, i), {31'b0, TxD}, {31'b0, e});
      chk($sformatf("%s busy cyc%0d", tag, i), {31'b0, TxBusy}, 32'd1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no end expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.MemWrite  = 1'b0;
    bus.Addr      = A_ST;
    bus.WriteData = '0;
    repeat (3) @(negedge clk);
    chk("in_reset txd", {31'b0, TxD}, 32'd1);
    chk("in_reset busy", {31'b0, TxBusy}, 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // Reset state and address decode
    bus_rd(A_ST, 32'h0000_0002, "rst status");
    bus_rd(A_BAUD, 32'h0000_0010, "rst bauddiv");
    chk("rst sel", {31'b0, bus.Sel}, 32'd1);
    bus_rd(A_TX, 32'h0, "txdata reads 0");
    chk("rst txd", {31'b0, TxD}, 32'd1);

    // Single frame 0xA5 at div=4
    bus_wr(A_BAUD, 32'd4);
    bus_wr(A_TX, 32'hA5);
    bus_rd(A_ST, 32'h0000_0010, "after push status");
    check_frame(8'hA5, 4, "f_a5");
    @(negedge clk);
    chk("f_a5 idle busy", {31'b0, TxBusy}, 32'd0);
    chk("f_a5 idle txd", {31'b0, TxD}, 32'd1);

    // Five back-to-back writes, sixth overflows, frames contiguous
    fork
      begin
        @(negedge clk);
        check_frame(8'h11, 4, "b2b0");
        check_frame(8'h22, 4, "b2b1");
        check_frame(8'h33, 4, "b2b2");
        check_frame(8'h44, 4, "b2b3");
        check_frame(8'h55, 4, "b2b4");
      end
      begin
        bus_wr(A_TX, 32'h11);
        bus_wr(A_TX, 32'h22);
        bus_wr(A_TX, 32'h33);
        bus_wr(A_TX, 32'h44);
        bus_wr(A_TX, 32'h55);
        bus_rd(A_ST, 32'h0000_0045, "full no ovf");
        bus_wr(A_TX, 32'h66);
        bus_rd(A_ST, 32'h0000_004D, "ovf set");
        bus_wr(A_ST, 32'h0000_0008);
        bus_rd(A_ST, 32'h0000_0045, "ovf cleared");
      end
    join
    @(negedge clk);
    chk("b2b idle busy", {31'b0, TxBusy}, 32'd0);
    bus_rd(A_ST, 32'h0000_0002, "b2b drained");

    // Divisor change mid-frame applies to the next frame only
    fork
      begin
        @(negedge clk);
        check_frame(8'h3C, 4, "div4");
        check_frame(8'hC3, 8, "div8");
      end
      begin
        bus_wr(A_TX, 32'h3C);
        bus_wr(A_TX, 32'hC3);
        repeat (10) @(negedge clk);
        bus_wr(A_BAUD, 32'd8);
        bus_rd(A_BAUD, 32'h0000_0008, "bauddiv 8");
      end
    join
    @(negedge clk);
    chk("div8 idle busy", {31'b0, TxBusy}, 32'd0);

    // Divisor 0 behaves as 1
    bus_wr(A_BAUD, 32'd0);
    bus_rd(A_BAUD, 32'h0, "bauddiv 0");
    bus_wr(A_TX, 32'h01);
    check_frame(8'h01, 1, "div0");
    @(negedge clk);
    chk("div0 idle busy", {31'b0, TxBusy}, 32'd0);

    // Asynchronous reset mid-frame
    bus_wr(A_BAUD, 32'd4);
    bus_wr(A_TX, 32'h00);
    bus_wr(A_TX, 32'h0F);
    repeat (7) @(negedge clk);
    chk("pre-rst busy", {31'b0, TxBusy}, 32'd1);
    chk("pre-rst txd data", {31'b0, TxD}, 32'd0);
    reset = 1'b0;
    #1;
    chk("async rst txd", {31'b0, TxD}, 32'd1);
    chk("async rst busy", {31'b0, TxBusy}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    bus_rd(A_ST, 32'h0000_0002, "post-rst status");
    bus_rd(A_BAUD, 32'h0000_0010, "post-rst bauddiv");

    // Out-of-window and reserved accesses
    bus.Addr = A_OUT;
    #1;
    chk("out sel", {31'b0, bus.Sel}, 32'd0);
    chk("out rddata", bus.RdData, 32'h0);
    bus_wr(A_OUT, 32'h0000_0077);
    bus.Addr = A_RSV;
    #1;
    chk("rsv sel", {31'b0, bus.Sel}, 32'd1);
    chk("rsv rddata", bus.RdData, 32'h0);
    bus_wr(A_RSV, 32'hFFFF_FFFF);
    bus_rd(A_ST, 32'h0000_0002, "no push status");
    bus_rd(A_BAUD, 32'h0000_0010, "rsv no baud");
    repeat (2) @(negedge clk);
    chk("no push busy", {31'b0, TxBusy}, 32'd0);
    chk("no push txd", {31'b0, TxD}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
